// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_scanner
// Purpose  : Walks a 5-bit vector through all 32 values and captures the
//            sampled response of a downstream function.
// Revision : 1.0  initial release
// ============================================================================
module truth_table_scanner #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        y_in,
    output logic [4:0]  x_out,
    output logic        busy,
    output logic        done,
    output logic        valid,
    // "table" is a reserved word, so the captured table uses this name
    output logic [31:0] truth_table,
    output logic [5:0]  ones
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);
    localparam logic [4:0] c_last_vec    = 5'd31;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [4:0]  r_x;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [31:0] r_table;
    logic [5:0]  r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_table <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // abort beats start; neither takes effect together
                    if (start && !abort) begin
                        r_state <= S_DRIVE;
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_table <= '0;
                        r_ones  <= '0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else if (r_cnt == c_settle_last) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_table[r_x] <= y_in;
                        r_ones       <= r_ones + {5'd0, y_in};
                        if (r_x == c_last_vec) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRIVE;
                            r_x     <= r_x + 5'd1;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_valid <= 1'b1;
                    r_x     <= '0;
                end
            endcase
        end
    end

    assign x_out       = r_x;
    assign busy        = r_busy;
    assign done        = r_done;
    assign valid       = r_valid;
    assign truth_table = r_table;
    assign ones        = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_scanner
// Purpose  : Self-checking bench; two scanners (SETTLE=1 and SETTLE=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, abort1, y1;
    logic        rst3, start3, abort3, y3;
    logic [4:0]  x1, x3;
    logic        busy1, busy3, done1, done3, valid1, valid3;
    logic [31:0] tt1, tt3;
    logic [5:0]  ones1, ones3;
    int          mode1, mode3;

    truth_table_scanner #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .y_in(y1),
        .x_out(x1), .busy(busy1), .done(done1), .valid(valid1),
        .truth_table(tt1), .ones(ones1)
    );

    truth_table_scanner #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .abort(abort3), .y_in(y3),
        .x_out(x3), .busy(busy3), .done(done3), .valid(valid3),
        .truth_table(tt3), .ones(ones3)
    );

    // downstream function models: 0 -> const 1, 1 -> x[0], 2 -> (x==31)
    function automatic logic fn(input int m, input logic [4:0] x);
        case (m)
            1:       return x[0];
            2:       return (x == 5'd31);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        y1 = fn(mode1, x1);
        y3 = fn(mode3, x3);
    end

    typedef struct packed {
        logic [31:0] t;
        logic [5:0]  o;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0]  g_x(input int s);     return s ? x3 : x1;        endfunction
    function automatic logic        g_busy(input int s);  return s ? busy3 : busy1;  endfunction
    function automatic logic        g_done(input int s);  return s ? done3 : done1;  endfunction
    function automatic logic        g_valid(input int s); return s ? valid3 : valid1; endfunction
    function automatic logic [31:0] g_tt(input int s);    return s ? tt3 : tt1;      endfunction
    function automatic logic [5:0]  g_ones(input int s);  return s ? ones3 : ones1;  endfunction

    task automatic set_start(input int s, input logic v);
        if (s != 0) start3 = v; else start1 = v;
    endtask

    task automatic pop_cmp(input int s, input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_table"}, g_tt(s), e.t);
            chk({tag, "_ones"}, {26'd0, g_ones(s)}, {26'd0, e.o});
        end
    endtask

    task automatic check_zero(input int s, input string tag);
        chk({tag, "_x"}, {27'd0, g_x(s)}, 32'd0);
        chk({tag, "_busy"}, {31'd0, g_busy(s)}, 32'd0);
        chk({tag, "_done"}, {31'd0, g_done(s)}, 32'd0);
        chk({tag, "_valid"}, {31'd0, g_valid(s)}, 32'd0);
        chk({tag, "_table"}, g_tt(s), 32'd0);
        chk({tag, "_ones"}, {26'd0, g_ones(s)}, 32'd0);
    endtask

    // Full scan: checks stepping, latency, captured result and post-done state.
    task automatic run_scan(input int s, input logic [31:0] et, input logic [5:0] eo);
        int n;
        int st;
        st = (s != 0) ? 3 : 1;
        exp_q.push_back('{t: et, o: eo});
        @(negedge clk) set_start(s, 1'b1);
        @(negedge clk) set_start(s, 1'b0);
        n = 0;
        while (!g_done(s) && n < 300) begin
            chk("x_step", {27'd0, g_x(s)}, 32'(n / (st + 1)));
            chk("busy_scan", {31'd0, g_busy(s)}, 32'd1);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(32 * (st + 1)));
        chk("done_busy", {31'd0, g_busy(s)}, 32'd0);
        chk("done_x", {27'd0, g_x(s)}, 32'd31);
        pop_cmp(s, "scan");
        @(negedge clk);
        chk("post_valid", {31'd0, g_valid(s)}, 32'd1);
        chk("post_done", {31'd0, g_done(s)}, 32'd0);
        chk("post_x", {27'd0, g_x(s)}, 32'd0);
    endtask

    task automatic wait_x(input int s, input logic [4:0] target);
        int n;
        n = 0;
        while (g_x(s) != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_x_bound", {31'd0, (g_x(s) == target)}, 32'd1);
    endtask

    initial begin
        bit saw_done;
        rst1 = 1'b1; rst3 = 1'b1;
        start1 = 1'b0; start3 = 1'b0; abort1 = 1'b0; abort3 = 1'b0;
        mode1 = 0; mode3 = 0;
        repeat (3) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        check_zero(0, "reset1");
        check_zero(1, "reset3");

        // start and abort together in IDLE: nothing happens
        @(negedge clk) begin start1 = 1'b1; abort1 = 1'b1; end
        @(negedge clk) begin start1 = 1'b0; abort1 = 1'b0; end
        chk("idle_abort_busy", {31'd0, busy1}, 32'd0);
        chk("idle_abort_x", {27'd0, x1}, 32'd0);

        mode1 = 0;
        run_scan(0, 32'hFFFF_FFFF, 6'd32);
        mode1 = 1;
        run_scan(0, 32'hAAAA_AAAA, 6'd16);
        mode3 = 2;
        run_scan(1, 32'h8000_0000, 6'd1);

        // abort mid-scan at x_out=10
        mode1 = 0;
        exp_q.push_back('{t: 32'h0000_03FF, o: 6'd10});
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        chk("abort_valid_cleared", {31'd0, valid1}, 32'd0);
        wait_x(0, 5'd10);
        abort1 = 1'b1;
        @(negedge clk) abort1 = 1'b0;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_x", {27'd0, x1}, 32'd0);
        chk("abort_valid", {31'd0, valid1}, 32'd0);
        pop_cmp(0, "abort");
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done1) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_hold_ones", {26'd0, ones1}, 32'd10);

        // extra start while busy, then reset at x_out=20
        mode1 = 1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_x(0, 5'd5);
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_x(0, 5'd20);
        chk("extra_start_ones", {26'd0, ones1}, 32'd10);
        rst1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk) begin rst1 = 1'b0; start1 = 1'b0; end
        check_zero(0, "midreset");
        run_scan(0, 32'hAAAA_AAAA, 6'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles each input vector is held before y_in is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  single-cycle request to begin a 32-vector scan.
REQ-005 Port: abort  input  1  terminates a scan in progress.
REQ-006 Port: y_in  input  1  response of the downstream 5-input combinational function to x_out.
REQ-007 Port: x_out  output  5  input vector driven to the downstream function.
REQ-008 Port: busy  output  1  high while a scan is in progress.
REQ-009 Port: done  output  1  one-cycle pulse on scan completion.
REQ-010 Port: valid  output  1  table and ones hold a complete, unaborted scan.
REQ-011 Port: table  output  32  captured truth table; bit i equals y_in sampled while x_out == i.
REQ-012 Port: ones  output  6  count of 1 bits captured in the current or last scan, range 0..32.

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, DONE; all outputs are registered.
REQ-014 IDLE with start=1 and abort=0: next state DRIVE; x_out<=0; table<=0; ones<=0; valid<=0; settle counter<=0.
REQ-015 start outside IDLE shall be ignored; it has no effect on the scan in progress.
REQ-016 DRIVE: x_out held constant; settle counter increments each cycle; on the cycle the counter equals SETTLE-1, next state SAMPLE.
REQ-017 SAMPLE: on the exiting edge, table[x_out]<=y_in and ones<=ones+y_in.
REQ-018 SAMPLE with x_out < 31: x_out<=x_out+1; settle counter<=0; next state DRIVE.
REQ-019 SAMPLE with x_out == 31: x_out stays 31; next state DONE; no wrap to 0 during the scan.
REQ-020 DONE: done=1 and valid<=1 on the exiting edge; next state IDLE; x_out<=0 on the exiting edge.
REQ-021 busy=1 in DRIVE and SAMPLE, 0 in IDLE and DONE.
REQ-022 Latency: the DRIVE->SAMPLE sequence per vector lasts exactly SETTLE+1 cycles; done is high in the cycle starting 32*(SETTLE+1) edges after the edge that samples start.
REQ-023 abort=1 in DRIVE or SAMPLE: next state IDLE; x_out<=0; valid<=0; done not pulsed; table and ones keep partial contents; no sample taken on that edge.
REQ-024 abort=1 in IDLE or DONE shall be ignored; abort takes priority over start when both are high in IDLE, and neither takes effect.
REQ-025 table, ones, and valid hold their values in IDLE until the next accepted start or reset.
REQ-026 ones shall never exceed 32; its 6-bit width shall not overflow.

Reset
REQ-027 rst=1 at any clock edge, including mid-scan, forces state IDLE, x_out=0, busy=0, done=0, valid=0, table=0, ones=0, and settle counter=0, overriding start and abort.
REQ-028 The first start is accepted on the first edge with rst=0 and start=1.

Verification
REQ-029 SETTLE=1, y_in tied 1, start pulse -> done after 64 cycles; table=32'hFFFFFFFF; ones=32; valid=1.
REQ-030 SETTLE=1, y_in=x_out[0] -> table=32'hAAAAAAAA; ones=16; x_out steps 0..31, each value held 2 cycles.
REQ-031 SETTLE=3, y_in=(x_out==5'd31) -> done after 128 cycles; table=32'h80000000; ones=1.
REQ-032 Assert abort mid-scan at x_out=10, with y_in=1 -> IDLE next cycle; busy=0; no done pulse; valid=0; ones=10.
REQ-033 Assert start during busy, then assert rst at x_out=20 -> the extra start has no effect; after reset all outputs are 0, and a new start runs a full scan.
